// File: rtl/mips_regfile_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_regfile_wb : 32x32 MIPS register file, 2 async read / 1 sync write port,
// fed by the write-back mux. Optional macro RF_BYPASS_EN adds write-through. Rev 1.0
// ---------------------------------------------------------------------------
module mips_regfile_wb #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         ADDR_W   = 5,
  parameter logic [DATA_W-1:0]   SP_RESET = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0]   GP_RESET = 32'h0000_1800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [15:0]       wr_count,
  output logic              r0_wr_flag
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [15:0]       wr_count_q, wr_count_d;
  logic              r0_wr_flag_q, r0_wr_flag_d;
  logic              wr_en;
  logic              wr_zero;

  function automatic logic [DATA_W-1:0] reset_val(input int idx);
    if (idx == 29)      return SP_RESET;
    else if (idx == 28) return GP_RESET;
    else                return '0;
  endfunction

  assign wr_en   = we && !rst;
  assign wr_zero = (wa == '0);

  // Writes to $0 never touch storage or the commit counter; they only arm the flag.
  always_comb begin
    regs_d       = regs_q;
    wr_count_d   = wr_count_q;
    r0_wr_flag_d = r0_wr_flag_q;
    if (we) begin
      if (wr_zero) begin
        r0_wr_flag_d = 1'b1;
      end else begin
        regs_d[wa] = wd;
        if (wr_count_q != CNT_MAX) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= reset_val(i);
      end
      wr_count_q   <= '0;
      r0_wr_flag_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q   <= wr_count_d;
      r0_wr_flag_q <= r0_wr_flag_d;
    end
  end

  logic [DATA_W-1:0] rd1_arr, rd2_arr;

  always_comb begin
    rd1_arr = (ra1 == '0) ? '0 : regs_q[ra1];
    rd2_arr = (ra2 == '0) ? '0 : regs_q[ra2];
  end

`ifdef RF_BYPASS_EN
  // Write-through: a read hitting the in-flight write address sees wd now.
  always_comb begin
    rd1 = rd1_arr;
    rd2 = rd2_arr;
    if (wr_en && !wr_zero && (ra1 == wa)) rd1 = wd;
    if (wr_en && !wr_zero && (ra2 == wa)) rd2 = wd;
  end
`else
  logic unused_wr_en;
  assign unused_wr_en = wr_en;

  always_comb begin
    rd1 = rd1_arr;
    rd2 = rd2_arr;
  end
`endif

  assign wr_count   = wr_count_q;
  assign r0_wr_flag = r0_wr_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_regfile_wb : directed self-checking bench for mips_regfile_wb. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [15:0] wr_count;
  logic        r0_wr_flag;

  int n_checks = 0;
  int n_errors = 0;

  mips_regfile_wb dut (
    .clk        (clk),
    .rst        (rst),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .wr_count   (wr_count),
    .r0_wr_flag (r0_wr_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // Asynchronous reset asserted before the first rising edge.
    #2 rst = 1'b1;
    #1;
    ra1 = 5'd29; ra2 = 5'd28;
    #1;
    check("rst_sp", rd1, 32'h0000_3FFC);
    check("rst_gp", rd2, 32'h0000_1800);
    ra1 = 5'd5;
    #1;
    check("rst_r5", rd1, 32'h0);
    check("rst_cnt", {16'h0, wr_count}, 32'h0);
    check("rst_flag", {31'h0, r0_wr_flag}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    write(5'd8, 32'hDEADBEEF);
    ra1 = 5'd8; ra2 = 5'd8;
    #1;
    check("wr_r8_p1", rd1, 32'hDEADBEEF);
    check("wr_r8_p2", rd2, 32'hDEADBEEF);
    check("wr_cnt1", {16'h0, wr_count}, 32'd1);

    // $0 write: no bypass either, before the edge.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    check("r0_pre", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("r0_read", rd1, 32'h0);
    check("r0_flag", {31'h0, r0_wr_flag}, 32'h1);
    check("r0_cnt", {16'h0, wr_count}, 32'd1);

    // Read during write.
    write(5'd9, 32'h11);
    we = 1'b1; wa = 5'd9; wd = 32'h22; ra2 = 5'd9;
    #1;
`ifdef RF_BYPASS_EN
    check("rdw_pre", rd2, 32'h22);
`else
    check("rdw_pre", rd2, 32'h11);
`endif
    tick();
    we = 1'b0;
    #1;
    check("rdw_post", rd2, 32'h22);
    check("rdw_cnt", {16'h0, wr_count}, 32'd3);

    // Reset held across the edge while a write is pending.
    we = 1'b1; wa = 5'd10; wd = 32'h55; ra1 = 5'd10; ra2 = 5'd29;
    #2 rst = 1'b1;
    #1;
    check("rstw_rd_sp", rd2, 32'h0000_3FFC);
    check("rstw_rd10", rd1, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    check("rstw_r10", rd1, 32'h0);
    check("rstw_cnt", {16'h0, wr_count}, 32'h0);
    check("rstw_flag", {31'h0, r0_wr_flag}, 32'h0);
    ra2 = 5'd8;
    #1;
    check("rstw_r8", rd2, 32'h0);
    write(5'd10, 32'h55);
    check("post_rst_wr", rd1, 32'h55);
    check("post_rst_cnt", {16'h0, wr_count}, 32'd1);

    // Unknown address with we low must change nothing.
    wa = 5'bxxxxx; wd = 32'hAAAA_AAAA; we = 1'b0;
    tick();
    tick();
    check("xwa_r10", rd1, 32'h55);
    check("xwa_cnt", {16'h0, wr_count}, 32'd1);
    check("xwa_flag", {31'h0, r0_wr_flag}, 32'h0);

    // Saturation: count starts at 1, so 65534 writes reach 16'hFFFF.
    ra1 = 5'd3;
    for (int i = 0; i < 65533; i++) write(5'd3, i);
    check("sat_fffe", {16'h0, wr_count}, 32'h0000_FFFE);
    write(5'd3, 32'h1234_0000);
    check("sat_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    for (int i = 0; i < 6; i++) write(5'd3, 32'hC0DE_0000 + i);
    check("sat_hold", {16'h0, wr_count}, 32'h0000_FFFF);
    check("sat_r3", rd1, 32'hC0DE_0005);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
